// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the DMEM responder.
//   state_e  - responder FSM states (IDLE, WAIT, RESP)
//   size_e   - access size decoded from the byte / half-word request flags
//   OFS_*    - big-endian byte-lane offsets (addr[30:31] as a 2-bit value)
//   CNT_W    - width of the latency down-counter
package dmem_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Offset 0 is the most significant byte of the word (big-endian).
    localparam logic [1:0] OFS_B0 = 2'd0;
    localparam logic [1:0] OFS_B1 = 2'd1;
    localparam logic [1:0] OFS_B2 = 2'd2;
    localparam logic [1:0] OFS_B3 = 2'd3;
    localparam logic [1:0] OFS_H0 = 2'd0;
    localparam logic [1:0] OFS_H1 = 2'd2;

    // Byte flag wins over the half-word flag; neither set means a word access.
    function automatic size_e decode_size(input logic byte_f, input logic half_f);
        if (byte_f) begin
            return SZ_BYTE;
        end else if (half_f) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

    // Clears the low offset bits that do not belong to the access size.
    function automatic logic [1:0] force_align(input size_e size, input logic [1:0] ofs);
        case (size)
            SZ_HALF: return {ofs[1], 1'b0};
            SZ_WORD: return OFS_B0;
            default: return ofs;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational big-endian lane steering.
//   size        - access size
//   offset      - byte offset within the word (0 = most significant byte)
//   sign_ext    - sign-extend the extracted load value
//   mem_word    - current array word
//   store_data  - right-justified store data
//   load_value  - right-justified, extended load result
//   merged_word - array word with the addressed lanes replaced by store data
//   misaligned  - half-word at an odd offset, or word at a non-zero offset
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            OFS_B0:  byte_sel = mem_word[31:24];
            OFS_B1:  byte_sel = mem_word[23:16];
            OFS_B2:  byte_sel = mem_word[15:8];
            default: byte_sel = mem_word[7:0];
        endcase
        half_sel = (offset == OFS_H1) ? mem_word[15:0] : mem_word[31:16];
    end

    always_comb begin
        case (size)
            SZ_BYTE: load_value = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_value = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_value = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    OFS_B0:  merged_word[31:24] = store_data[7:0];
                    OFS_B1:  merged_word[23:16] = store_data[7:0];
                    OFS_B2:  merged_word[15:8]  = store_data[7:0];
                    default: merged_word[7:0]   = store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset == OFS_H1) begin
                    merged_word[15:0] = store_data[15:0];
                end else begin
                    merged_word[31:16] = store_data[15:0];
                end
            end
            default: merged_word = store_data;
        endcase
    end

    always_comb begin
        case (size)
            SZ_HALF: misaligned = offset[0];
            SZ_WORD: misaligned = (offset != OFS_B0);
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle DMEM responder with an internal word array.
// Accepts one load/store at a time, waits LATENCY cycles, then commits the
// access and pulses ready_to_proc for one cycle.
//   clock, reset          - clock; asynchronous active-high reset
//   req_from_proc         - request valid, held until ready_to_proc
//   addr_to_mem [0:31]    - byte address, bit 31 is the LSB
//   write_enable_to_mem   - 1 = store, 0 = load
//   byte_to_mem           - byte access (priority over half-word)
//   half_word_to_mem      - half-word access
//   sign_extend_to_mem    - sign-extend load results
//   data_to_mem [0:31]    - right-justified store data
//   data_from_mem [0:31]  - registered load result (held until next load)
//   ready_to_proc         - one-cycle completion pulse
//   busy                  - high from acceptance through the response cycle
//   err_to_proc           - misalignment flag, valid with ready_to_proc
// Build option: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses instead
// of silently forcing the low address bits to the access size.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_from_proc,
    input  logic [0:31] addr_to_mem,
    input  logic        write_enable_to_mem,
    input  logic        byte_to_mem,
    input  logic        half_word_to_mem,
    input  logic        sign_extend_to_mem,
    input  logic [0:31] data_to_mem,
    output logic [0:31] data_from_mem,
    output logic        ready_to_proc,
    output logic        busy,
    output logic        err_to_proc
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    // Port vectors are ascending; copying into descending vectors keeps the
    // numeric value, so port bit 31 (LSB) lands on internal bit 0.
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    assign addr_in  = addr_to_mem;
    assign wdata_in = data_to_mem;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_in[31:IDX_W+2];

    size_e            size_in;
    logic [1:0]       ofs_in;
    logic [IDX_W-1:0] idx_in;
    assign size_in = decode_size(byte_to_mem, half_word_to_mem);
    assign ofs_in  = addr_in[1:0];
    assign idx_in  = addr_in[IDX_W+1:2];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             we_q, we_d;
    size_e            size_q, size_d;
    logic             sext_q, sext_d;
    logic [1:0]       ofs_q, ofs_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             latch_req;
    logic             commit;

    // With LATENCY = 1 the commit happens on the accepting edge itself, before
    // the latched copy exists, so the live inputs are used while in IDLE.
    logic             eff_we;
    size_e            eff_size;
    logic             eff_sext;
    logic [1:0]       eff_ofs;
    logic [IDX_W-1:0] eff_idx;
    logic [31:0]      eff_wdata;

    always_comb begin
        if (state_q == S_IDLE) begin
            eff_we    = write_enable_to_mem;
            eff_size  = size_in;
            eff_sext  = sign_extend_to_mem;
            eff_ofs   = ofs_in;
            eff_idx   = idx_in;
            eff_wdata = wdata_in;
        end else begin
            eff_we    = we_q;
            eff_size  = size_q;
            eff_sext  = sext_q;
            eff_ofs   = ofs_q;
            eff_idx   = idx_q;
            eff_wdata = wdata_q;
        end
    end

    logic [1:0]  lane_ofs;
    logic        mis_err;
    logic [31:0] rd_word;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic        misaligned;

`ifdef DMEM_ALIGN_CHECK_EN
    assign lane_ofs = eff_ofs;
    assign mis_err  = misaligned;
`else
    logic unused_misaligned;
    assign lane_ofs          = force_align(eff_size, eff_ofs);
    assign mis_err           = 1'b0;
    assign unused_misaligned = misaligned;
`endif

    assign rd_word = mem_q[eff_idx];

    dmem_lane_align u_lane_align (
        .size        (eff_size),
        .offset      (lane_ofs),
        .sign_ext    (eff_sext),
        .mem_word    (rd_word),
        .store_data  (eff_wdata),
        .load_value  (load_value),
        .merged_word (merged_word),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_from_proc) begin
                    latch_req = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        ofs_d   = ofs_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        if (latch_req) begin
            we_d    = write_enable_to_mem;
            size_d  = size_in;
            sext_d  = sign_extend_to_mem;
            ofs_d   = ofs_in;
            idx_d   = idx_in;
            wdata_d = wdata_in;
        end
    end

    always_comb begin
        data_d  = data_q;
        ready_d = commit;
        busy_d  = (state_d != S_IDLE);
        err_d   = commit & mis_err;
        if (commit && !eff_we) begin
            data_d = mis_err ? '0 : load_value;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            sext_q  <= 1'b0;
            ofs_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            ofs_q   <= ofs_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Array is not reset; the reset gate keeps an edge during reset from
    // committing a store when LATENCY = 1.
    always_ff @(posedge clock) begin
        if (commit && eff_we && !mis_err && !reset) begin
            mem_q[eff_idx] <= merged_word;
        end
    end

    assign data_from_mem = data_q;
    assign ready_to_proc = ready_q;
    assign busy          = busy_q;
    assign err_to_proc   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_from_proc = 1'b0;
    logic [0:31] addr_to_mem = '0;
    logic        write_enable_to_mem = 1'b0;
    logic        byte_to_mem = 1'b0;
    logic        half_word_to_mem = 1'b0;
    logic        sign_extend_to_mem = 1'b0;
    logic [0:31] data_to_mem = '0;
    logic [0:31] data_from_mem;
    logic        ready_to_proc;
    logic        busy;
    logic        err_to_proc;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clock               (clock),
        .reset               (reset),
        .req_from_proc       (req_from_proc),
        .addr_to_mem         (addr_to_mem),
        .write_enable_to_mem (write_enable_to_mem),
        .byte_to_mem         (byte_to_mem),
        .half_word_to_mem    (half_word_to_mem),
        .sign_extend_to_mem  (sign_extend_to_mem),
        .data_to_mem         (data_to_mem),
        .data_from_mem       (data_from_mem),
        .ready_to_proc       (ready_to_proc),
        .busy                (busy),
        .err_to_proc         (err_to_proc)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request and waits (bounded) for its response.
    // lat = edges from the accepting edge's cycle to ready (-1 on timeout).
    task automatic do_access(input logic we, input logic bf, input logic hf, input logic sx,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rdata, output logic rerr,
                             output int lat, output int nbusy);
        rdata = 'x;
        rerr  = 1'bx;
        lat   = -1;
        nbusy = 0;
        @(negedge clock);
        write_enable_to_mem = we;
        byte_to_mem         = bf;
        half_word_to_mem    = hf;
        sign_extend_to_mem  = sx;
        addr_to_mem         = a;
        data_to_mem         = d;
        req_from_proc       = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            #1;
            if (busy) nbusy++;
            if (ready_to_proc) begin
                lat   = c;
                rdata = data_from_mem;
                rerr  = err_to_proc;
                break;
            end
        end
        @(negedge clock);
        req_from_proc = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (ready_to_proc !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_to_proc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err_to_proc !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_to_proc); end
        checks++; if (data_from_mem !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", data_from_mem); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic re; int lat; int nb;
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, rd, re, lat, nb);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_latency got %0d exp 2", lat); end
        checks++; if (nb !== 2) begin errors++; $display("FAIL word_store_busy got %0d exp 2", nb); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL word_store_err got %b exp 0", re); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_keeps_data got %h exp 00000000", rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_resp got %b exp 0", busy); end
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rd, re, lat, nb);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_latency got %0d exp 2", lat); end
        checks++; if (nb !== 2) begin errors++; $display("FAIL word_load_busy got %0d exp 2", nb); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data got %h exp deadbeef", rd); end
        checks++; if (data_from_mem !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_hold got %h exp deadbeef", data_from_mem); end
    endtask

    task automatic test_byte_loads;
        logic [31:0] rd; logic re; int lat; int nb;
        do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL byte_load_0x10_sx got %h exp ffffffde", rd); end
        do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h13, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'h000000EF) begin errors++; $display("FAIL byte_load_0x13 got %h exp 000000ef", rd); end
        do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'hFFFFFFAD) begin errors++; $display("FAIL byte_load_0x11_sx got %h exp ffffffad", rd); end
        // byte flag wins over the half-word flag
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h12, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'h000000BE) begin errors++; $display("FAIL byte_load_0x12 got %h exp 000000be", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic re; int lat; int nb;
        do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h12, 32'h00001234, rd, re, lat, nb);
        checks++; if (rd !== 32'h000000BE) begin errors++; $display("FAIL half_store_keeps_data got %h exp 000000be", rd); end
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'hDEAD1234) begin errors++; $display("FAIL half_store_word got %h exp dead1234", rd); end
        do_access(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL half_load_0x10_sx got %h exp ffffdead", rd); end
        do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h12, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL half_load_0x12 got %h exp 00001234", rd); end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd; logic re; int lat; int nb;
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h11223344, rd, re, lat, nb);
        do_access(1'b1, 1'b1, 1'b0, 1'b0, 32'h31, 32'hFFFFFFAB, rd, re, lat, nb);
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL byte_store_word got %h exp 11ab3344", rd); end
        do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h31, 32'h0, rd, re, lat, nb);
        checks++; if (rd !== 32'hFFFFFFAB) begin errors++; $display("FAIL byte_load_0x31_sx got %h exp ffffffab", rd); end
    endtask

    task automatic test_reset_wait;
        logic [31:0] rd; logic re; int lat; int nb; int pulses;
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, rd, re, lat, nb);
        pulses = 0;
        @(negedge clock);
        write_enable_to_mem = 1'b1;
        byte_to_mem         = 1'b0;
        half_word_to_mem    = 1'b0;
        addr_to_mem         = 32'h20;
        data_to_mem         = 32'h55;
        req_from_proc       = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b exp 1", busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
        checks++; if (data_from_mem !== 32'h0) begin errors++; $display("FAIL midreset_data got %h exp 00000000", data_from_mem); end
        req_from_proc = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (ready_to_proc) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL aborted_ready_pulses got %0d exp 0", pulses); end
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, rd, re, lat, nb);
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_reset_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL aborted_store_lost got %h exp 00000000", rd); end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic re; int lat; int nb;
        logic [31:0] exp_w; logic [31:0] exp_h; logic exp_e;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_w = 32'h0; exp_h = 32'h0; exp_e = 1'b1;
`else
        exp_w = 32'hDEAD1234; exp_h = 32'h00001234; exp_e = 1'b0;
`endif
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rd, re, lat, nb);
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h11, 32'h0, rd, re, lat, nb);
        checks++; if (lat !== 2) begin errors++; $display("FAIL misaligned_latency got %0d exp 2", lat); end
        checks++; if (re !== exp_e) begin errors++; $display("FAIL misaligned_word_err got %b exp %b", re, exp_e); end
        checks++; if (rd !== exp_w) begin errors++; $display("FAIL misaligned_word_data got %h exp %h", rd, exp_w); end
        checks++; if (err_to_proc !== 1'b0) begin errors++; $display("FAIL err_after_resp got %b exp 0", err_to_proc); end
        do_access(1'b0, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, rd, re, lat, nb);
        checks++; if (re !== exp_e) begin errors++; $display("FAIL misaligned_half_err got %b exp %b", re, exp_e); end
        checks++; if (rd !== exp_h) begin errors++; $display("FAIL misaligned_half_data got %h exp %h", rd, exp_h); end
    endtask

    task automatic test_back_to_back;
        int lat1; int lat2; logic idle_busy; logic [31:0] rd;
        lat1 = -1; lat2 = -1; idle_busy = 1'bx; rd = 'x;
        @(negedge clock);
        write_enable_to_mem = 1'b1;
        byte_to_mem         = 1'b0;
        half_word_to_mem    = 1'b0;
        sign_extend_to_mem  = 1'b0;
        addr_to_mem         = 32'h1000;
        data_to_mem         = 32'hCAFEF00D;
        req_from_proc       = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            #1;
            if (ready_to_proc) begin lat1 = c; break; end
        end
        @(negedge clock);
        write_enable_to_mem = 1'b0;
        addr_to_mem         = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) idle_busy = busy;
            if (ready_to_proc) begin lat2 = c; rd = data_from_mem; break; end
        end
        @(negedge clock);
        req_from_proc = 1'b0;
        @(posedge clock);
        #1;
        checks++; if (lat1 !== 2) begin errors++; $display("FAIL b2b_first_latency got %0d exp 2", lat1); end
        checks++; if (idle_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap_busy got %b exp 0", idle_busy); end
        checks++; if (lat2 !== 3) begin errors++; $display("FAIL b2b_second_spacing got %0d exp 3", lat2); end
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_load_0x0 got %h exp cafef00d", rd); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte_loads;
        test_half;
        test_byte_store;
        test_reset_wait;
        test_misaligned;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
